// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, redirect
// target selector codes, default bubble word and an alignment helper.
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam logic [1:0] PCTYPE_BRANCH = 2'b00;
  localparam logic [1:0] PCTYPE_JREG   = 2'b01;
  localparam logic [1:0] PCTYPE_JIDX   = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request port: fetch drives enable/address, memory
// returns the word together with a same-cycle ready.
interface fetch_unit_if;
  logic        if_mc_en;
  logic [31:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mc_if_ready;

  modport master (
    output if_mc_en,
    output if_mc_addr,
    input  mc_if_data,
    input  mc_if_ready
  );

  modport slave (
    input  if_mc_en,
    input  if_mc_addr,
    output mc_if_data,
    output mc_if_ready
  );
endinterface

// File: rtl/fetch_target_mux.sv
// Redirect target selection with forced word alignment; also reports when
// the raw target had nonzero low bits. Reused by exception-vector logic.
module fetch_target_mux
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  sel_type,
  input  logic [31:0] branch_target,
  input  logic [31:0] reg_target,
  input  logic [31:0] index_target,
  output logic [31:0] target_aligned,
  output logic        misaligned
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = branch_target;
    case (sel_type)
      PCTYPE_JREG: raw_target = reg_target;
      PCTYPE_JIDX: raw_target = index_target;
      default:     raw_target = branch_target;  // 11 behaves like a branch
    endcase
  end

  assign target_aligned = word_align(raw_target);
  assign misaligned     = |raw_target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory request handshake, IF/ID register and
// delayed (one delay slot) redirect. Macro FETCH_MISALIGN_EN enables the
// sticky misaligned-target flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         id_if_selpcsource,
  input  logic [1:0]   id_if_selpctype,
  input  logic [31:0]  id_if_rega,
  input  logic [31:0]  id_if_pcimd2ext,
  input  logic [31:0]  id_if_pcindex,
  fetch_unit_if.master mem,
  output logic [31:0]  if_id_instruc,
  output logic [31:0]  if_id_nextpc,
  output logic         if_err_misalign
);

`ifdef FETCH_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  redir_pc_reg, redir_pc_next;
  logic         pending_reg, pending_next;
  logic [31:0]  instruc_reg, instruc_next;
  logic [31:0]  nextpc_reg, nextpc_next;
  logic         misalign_reg, misalign_next;

  logic [31:0]  target_aligned;
  logic         target_misaligned;
  logic [31:0]  pc_plus4;
  logic         complete;

  fetch_target_mux u_target_mux (
    .sel_type       (id_if_selpctype),
    .branch_target  (id_if_pcimd2ext),
    .reg_target     (id_if_rega),
    .index_target   (id_if_pcindex),
    .target_aligned (target_aligned),
    .misaligned     (target_misaligned)
  );

  assign pc_plus4 = pc_reg + 32'd4;
  assign complete = (state_reg == FETCH) && mem.mc_if_ready;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    redir_pc_next  = redir_pc_reg;
    pending_next   = pending_reg;
    instruc_next   = NOP_WORD;
    nextpc_next    = nextpc_reg;
    misalign_next  = misalign_reg;
    mem.if_mc_en   = 1'b0;
    mem.if_mc_addr = pc_reg;

    case (state_reg)
      BOOT:    state_next = FETCH;
      FETCH: begin
        state_next   = FETCH;
        mem.if_mc_en = 1'b1;
      end
      default: state_next = BOOT;
    endcase

    if (id_if_selpcsource) begin
      redir_pc_next = target_aligned;
      pending_next  = 1'b1;
      misalign_next = misalign_reg | (MISALIGN_EN & target_misaligned);
    end

    // The request in flight is the delay slot; the target follows it.
    if (complete) begin
      instruc_next = mem.mc_if_data;
      nextpc_next  = pc_plus4;
      pending_next = 1'b0;
      if (id_if_selpcsource)
        pc_next = target_aligned;
      else if (pending_reg)
        pc_next = redir_pc_reg;
      else
        pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      redir_pc_reg <= 32'h0000_0000;
      pending_reg  <= 1'b0;
      instruc_reg  <= NOP_WORD;
      nextpc_reg   <= 32'h0000_0000;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      redir_pc_reg <= redir_pc_next;
      pending_reg  <= pending_next;
      instruc_reg  <= instruc_next;
      nextpc_reg   <= nextpc_next;
      misalign_reg <= misalign_next;
    end
  end

  assign if_id_instruc   = instruc_reg;
  assign if_id_nextpc    = nextpc_reg;
  assign if_err_misalign = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table followed by randomized traffic
// checked against a program-order model of the fetch stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] DATA_TAG = 32'hC000_0000;  // memory returns addr ^ tag
  localparam logic [31:0] NOP      = NOP_WORD_DEFAULT;
  localparam logic [31:0] JUNK     = 32'h0BAD_0F00;
`ifdef FETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  typ;
  logic [31:0] rega, imd, idx;
  logic        rdy;
  logic [31:0] if_id_instruc, if_id_nextpc;
  logic        if_err_misalign;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit_if mem ();
  assign mem.mc_if_data  = mem.if_mc_addr ^ DATA_TAG;
  assign mem.mc_if_ready = rdy;

  fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .id_if_selpcsource (sel),
    .id_if_selpctype   (typ),
    .id_if_rega        (rega),
    .id_if_pcimd2ext   (imd),
    .id_if_pcindex     (idx),
    .mem               (mem),
    .if_id_instruc     (if_id_instruc),
    .if_id_nextpc      (if_id_nextpc),
    .if_err_misalign   (if_err_misalign)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, rdy, sel;
    logic [1:0]  typ;
    logic [31:0] imd, rega, idx;
    logic        chk_pre, exp_en;
    logic [31:0] exp_addr, exp_ins, exp_npc;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] tgt;
  } redir_t;

  vec_t   vq[$];
  redir_t rq[$];

  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ DATA_TAG;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic y, input logic s, input logic [1:0] t,
                     input logic [31:0] tgt, input logic chk, input logic en,
                     input logic [31:0] addr, input logic [31:0] ins,
                     input logic [31:0] npc, input logic mis);
    vec_t v;
    v.rst = r; v.rdy = y; v.sel = s; v.typ = t;
    v.imd  = (t == 2'b01 || t == 2'b10) ? JUNK : tgt;
    v.rega = (t == 2'b01) ? tgt : JUNK;
    v.idx  = (t == 2'b10) ? tgt : JUNK;
    v.chk_pre = chk; v.exp_en = en; v.exp_addr = addr;
    v.exp_ins = ins; v.exp_npc = npc; v.exp_mis = mis & MIS_EN;
    vq.push_back(v);
  endtask

  // Reference model state (random phase)
  logic        m_boot;
  logic [31:0] m_pc, m_ins, m_npc;
  logic        m_mis;
  int          m_count;
  logic        last_done;

  initial begin
    reset = 1'b1; rdy = 1'b0; sel = 1'b0; typ = 2'b00;
    rega = 32'h0; imd = 32'h0; idx = 32'h0;

    // rst rdy sel typ target | chk en addr | instruc nextpc mis
    add(1, 0, 0, 2'b00, 0,            0, 0, 0,            NOP,                0,            0);
    add(0, 1, 0, 2'b00, 0,            1, 0, 0,            NOP,                0,            0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h0,        d(32'h0),           32'h4,        0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h4,        d(32'h4),           32'h8,        0);
    add(0, 0, 0, 2'b00, 0,            1, 1, 32'h8,        NOP,                32'h8,        0);
    add(0, 0, 0, 2'b00, 0,            1, 1, 32'h8,        NOP,                32'h8,        0);
    add(0, 0, 0, 2'b00, 0,            1, 1, 32'h8,        NOP,                32'h8,        0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h8,        d(32'h8),           32'hC,        0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'hC,        d(32'hC),           32'h10,       0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h10,       d(32'h10),          32'h14,       0);
    add(0, 1, 1, 2'b00, 32'h100,      1, 1, 32'h14,       d(32'h14),          32'h18,       0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h100,      d(32'h100),         32'h104,      0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h104,      d(32'h104),         32'h108,      0);
    add(0, 0, 1, 2'b01, 32'h2000,     1, 1, 32'h108,      NOP,                32'h108,      0);
    add(0, 0, 0, 2'b00, 0,            1, 1, 32'h108,      NOP,                32'h108,      0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h108,      d(32'h108),         32'h10C,      0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h2000,     d(32'h2000),        32'h2004,     0);
    add(0, 1, 1, 2'b10, 32'h402,      1, 1, 32'h2004,     d(32'h2004),        32'h2008,     1);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h400,      d(32'h400),         32'h404,      1);
    add(0, 1, 1, 2'b11, 32'h600,      1, 1, 32'h404,      d(32'h404),         32'h408,      1);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h600,      d(32'h600),         32'h604,      1);
    add(0, 1, 1, 2'b00, 32'h2C,       1, 1, 32'h604,      d(32'h604),         32'h608,      1);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h2C,       d(32'h2C),          32'h30,       1);
    add(0, 0, 0, 2'b00, 0,            1, 1, 32'h30,       NOP,                32'h30,       1);
    add(1, 0, 0, 2'b00, 0,            1, 1, 32'h30,       NOP,                0,            0);
    add(0, 1, 0, 2'b00, 0,            1, 0, 0,            NOP,                0,            0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h0,        d(32'h0),           32'h4,        0);
    add(0, 1, 1, 2'b00, 32'hFFFF_FFFC, 1, 1, 32'h4,       d(32'h4),           32'h8,        0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'hFFFF_FFFC, d(32'hFFFF_FFFC),  32'h0,        0);
    add(0, 1, 0, 2'b00, 0,            1, 1, 32'h0,        d(32'h0),           32'h4,        0);

    @(posedge clock); #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; rdy = vq[i].rdy; sel = vq[i].sel; typ = vq[i].typ;
      imd = vq[i].imd; rega = vq[i].rega; idx = vq[i].idx;
      #1;
      if (vq[i].chk_pre) begin
        check($sformatf("vec%0d_en", i), {31'b0, mem.if_mc_en}, {31'b0, vq[i].exp_en});
        if (vq[i].exp_en)
          check($sformatf("vec%0d_addr", i), mem.if_mc_addr, vq[i].exp_addr);
      end
      @(posedge clock); #1;
      check($sformatf("vec%0d_instruc", i), if_id_instruc, vq[i].exp_ins);
      check($sformatf("vec%0d_nextpc", i), if_id_nextpc, vq[i].exp_npc);
      check($sformatf("vec%0d_misalign", i), {31'b0, if_err_misalign}, {31'b0, vq[i].exp_mis});
      $display("vec %0d: rst=%0b rdy=%0b sel=%0b typ=%0d -> instruc=%h nextpc=%h mis=%0b",
               i, vq[i].rst, vq[i].rdy, vq[i].sel, vq[i].typ,
               if_id_instruc, if_id_nextpc, if_err_misalign);
    end

    // Randomized traffic against the program-order model
    m_boot = 1'b1; m_pc = 32'h0; m_ins = NOP; m_npc = 32'h0; m_mis = 1'b0;
    m_count = 0; last_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic        do_rst, done;
      logic [31:0] tgt;
      do_rst = (c == 0) || ($urandom_range(0, 99) == 0);
      rdy    = ($urandom_range(0, 3) != 0);
      sel    = !do_rst && last_done && (rq.size() == 0) && ($urandom_range(0, 2) == 0);
      typ    = 2'($urandom);
      imd    = $urandom; rega = $urandom; idx = $urandom;
      reset  = do_rst;
      if (sel && rq.size() != 0)
        $fatal(1, "FAIL redirect_while_pending: got 1 expected 0");
      #1;
      if (c != 0) begin
        check("rand_en", {31'b0, mem.if_mc_en}, {31'b0, !m_boot});
        if (!m_boot) check("rand_addr", mem.if_mc_addr, m_pc);
      end

      done = 1'b0;
      if (do_rst) begin
        m_boot = 1'b1; m_pc = 32'h0; m_ins = NOP; m_npc = 32'h0; m_mis = 1'b0;
        m_count = 0; rq.delete();
      end else begin
        if (sel) begin
          tgt = (typ == 2'b01) ? rega : (typ == 2'b10) ? idx : imd;
          // the target is the second instruction after the one on IF/ID
          rq.push_back('{idx: m_count + 1, tgt: tgt & 32'hFFFF_FFFC});
          if (MIS_EN && tgt[1:0] != 2'b00) m_mis = 1'b1;
        end
        if (m_boot) begin
          m_boot = 1'b0; m_ins = NOP;
        end else if (rdy) begin
          done  = 1'b1;
          m_ins = d(m_pc);
          m_npc = m_pc + 32'd4;
          if (rq.size() != 0 && rq[0].idx == m_count + 1) begin
            m_pc = rq[0].tgt;
            void'(rq.pop_front());
          end else begin
            m_pc = m_pc + 32'd4;
          end
          m_count++;
        end else begin
          m_ins = NOP;
        end
      end
      last_done = done;

      @(posedge clock); #1;
      check("rand_instruc", if_id_instruc, m_ins);
      check("rand_nextpc", if_id_nextpc, m_npc);
      check("rand_misalign", {31'b0, if_err_misalign}, {31'b0, m_mis});
      if (done)
        $display("rand %0d: fetch #%0d instruc=%h nextpc=%h redirect=%0b",
                 c, m_count, if_id_instruc, if_id_nextpc, sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the decode stage. Holds the program counter and requests instructions from the instruction-memory port with a ready handshake. Each cycle it registers either the fetched word or a NOP bubble into the IF/ID outputs. It applies decode's redirect (branch / jump-register / jump-index) after exactly one delay-slot instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_WORD`, default 32'h0000_0000: bubble word driven when no instruction completes.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `id_if_selpcsource` in 1: redirect request from decode; applies to the instruction currently on `if_id_instruc`.
- `id_if_selpctype` in 2: target select. 00 = `id_if_pcimd2ext`, 01 = `id_if_rega`, 10 = `id_if_pcindex`, 11 = treated as 00.
- `id_if_rega` in 32: jump-register target.
- `id_if_pcimd2ext` in 32: branch target.
- `id_if_pcindex` in 32: jump-index target.
- `if_mc_en` out 1: fetch request valid.
- `if_mc_addr` out 32: fetch address, word aligned.
- `mc_if_data` in 32: instruction word, valid when `mc_if_ready` = 1.
- `mc_if_ready` in 1: completes the request in the current cycle.
- `if_id_instruc` out 32: registered instruction to decode.
- `if_id_nextpc` out 32: registered address of that instruction + 4.
- `if_err_misalign` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- States:
  - BOOT: entered on reset, lasts one cycle, `if_mc_en` = 0.
  - FETCH: `if_mc_en` = 1, `if_mc_addr` = `pc`.
- Transitions: BOOT → FETCH unconditionally. FETCH → FETCH. Reset → BOOT from any state.
- Handshake:
  - In FETCH, address and enable are held stable until a rising edge where `mc_if_ready` = 1.
  - Ready while `if_mc_en` = 0 is ignored.
- On a completing edge:
  - `if_id_instruc` ← `mc_if_data`.
  - `if_id_nextpc` ← `pc` + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - `pc` ← `redir_pc` if a redirect is pending or arriving this cycle, otherwise `pc` + 4. The pending flag then clears.
- On a non-completing edge:
  - `if_id_instruc` ← `NOP_WORD`.
  - `if_id_nextpc` holds its value.
  - `pc` holds its value.
- Redirect capture:
  - When `id_if_selpcsource` = 1, the target selected by `id_if_selpctype` is captured into `redir_pc` and the pending flag is set.
  - The fetch in flight is the delay slot and is never squashed.
  - If that delay-slot fetch completes in the same cycle, `pc` takes the target directly with no pending cycle.
- The decode stage has no stall, so a branch occupies IF/ID for exactly one cycle. A second redirect cannot arrive while one is pending; the bench asserts this.
- Targets are forced word aligned: bits [1:0] are cleared.

## Timing
- Reset values: `pc` = `RESET_PC`, state = BOOT, pending flag = 0, `if_mc_en` = 0, `if_id_instruc` = `NOP_WORD`, `if_id_nextpc` = 0, `if_err_misalign` = 0.
- First request is issued in the cycle after reset deasserts.
- Latency: an instruction completing at edge N appears on `if_id_instruc` after edge N.
- Zero-wait memory sustains one instruction per cycle.
- Taken redirect: decode sees the branch in cycle N, sees the delay slot in N+1 (at the earliest), and sees the target instruction in N+2 (at the earliest).
- Reset mid-request abandons the request; the memory model must accept an enable dropping without ready.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A captured target with bits [1:0] ≠ 0 sets `if_err_misalign`.
  - The flag stays set until reset.
  - Fetch continues at the aligned address.
- `FETCH_MISALIGN_EN` undefined: `if_err_misalign` is tied to 0 and low target bits are dropped silently.

## Structure
- Shared package holds:
  - state enum (BOOT, FETCH)
  - `PCTYPE_BRANCH` = 2'b00, `PCTYPE_JREG` = 2'b01, `PCTYPE_JIDX` = 2'b10
  - `NOP_WORD` default.
- Sub-module `fetch_target_mux`: combinational selection of the redirect target plus alignment and misalignment detection. It is shared with the future exception-vector logic.

## Test plan
- Reset then zero-wait memory returning address-as-data → `if_mc_addr` sequence 0, 4, 8; `if_id_nextpc` 4, 8, 12; first non-NOP word one cycle after the first request.
- Ready low for 3 cycles at addr 8 → `if_mc_addr` held at 8, three `NOP_WORD` outputs, then word 8 with `if_id_nextpc` = 12.
- Branch at 0x10 with selpctype 00 and target 0x100, zero-wait memory → delay slot 0x14 fetched, next address 0x100.
- Jump-register (01, rega 0x2000) while the delay-slot fetch is stalled 2 cycles → target held pending, fetch at 0x2000 follows delay-slot completion.
- selpctype 10 with pcindex 0x0000_0402 → fetch at 0x400; `if_err_misalign` = 1 only when `FETCH_MISALIGN_EN` is defined.
- `reset` asserted while a fetch at 0x30 waits on ready → next cycle BOOT outputs, then fetch restarts at `RESET_PC`.
